// File: rtl/hvsync_receiver_if.sv
// Sync inputs and recovered-timing outputs of hvsync_receiver, bundled for port use.
// master = timing source/consumer side, slave = the receiver itself.
interface hvsync_receiver_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       locked;
    logic       sync_err;
    logic [9:0] line_len;

    modport master (
        output hsync,
        output vsync,
        input  hpos,
        input  vpos,
        input  display_on,
        input  locked,
        input  sync_err,
        input  line_len
    );

    modport slave (
        input  hsync,
        input  vsync,
        output hpos,
        output vpos,
        output display_on,
        output locked,
        output sync_err,
        output line_len
    );
endinterface

// File: rtl/hvsync_receiver.sv
// Recovers hpos/vpos from asynchronous hsync/vsync, measures line length and
// declares lock once a whole frame with the expected geometry has been seen.
module hvsync_receiver #(
    parameter int H_MAX      = 799,
    parameter int V_MAX      = 524,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int H_EDGE_POS = 660,
    parameter int V_EDGE_POS = 509
) (
    input  logic             clk,
    input  logic             reset,
    hvsync_receiver_if.slave sync_if
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] H_MAX_C     = 10'(H_MAX);
    localparam logic [9:0] V_MAX_C     = 10'(V_MAX);
    localparam logic [9:0] H_DISP_C    = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_C    = 10'(V_DISPLAY);
    localparam logic [9:0] H_EDGE_C    = 10'(H_EDGE_POS);
    localparam logic [9:0] V_EDGE_C    = 10'(V_EDGE_POS);
    localparam logic [9:0] LINE_CLKS   = 10'(H_MAX + 1);
    localparam logic [9:0] FRAME_LINES = 10'(V_MAX + 1);
    localparam logic [9:0] CNT_SAT     = 10'd1023;

    logic [2:0] hs_q, hs_d;
    logic [2:0] vs_q, vs_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] lcnt_q, lcnt_d;
    logic [9:0] line_len_q, line_len_d;
    logic       seen_q, seen_d;
    logic       bad_q, bad_d;
    logic       locked_q, locked_d;
    logic       sync_err_q, sync_err_d;
    state_t     state_q, state_d;

    logic       h_edge;
    logic       v_edge;
    logic       h_wrap;
    logic       timeout;
    logic       line_load;
    logic       bad_line;
    logic       frame_good;
    logic [9:0] meas_len;

    // [0],[1] synchronize, [2] is the history flop used for edge detection
    always_comb begin
        hs_d   = {hs_q[1:0], sync_if.hsync};
        vs_d   = {vs_q[1:0], sync_if.vsync};
        h_edge = hs_q[1] & ~hs_q[2];
        v_edge = vs_q[1] & ~vs_q[2];
    end

    always_comb begin
        h_wrap = !h_edge && (hpos_q == H_MAX_C);

        hpos_d = hpos_q + 10'd1;
        if (h_edge) begin
            hpos_d = H_EDGE_C;
        end else if (hpos_q == H_MAX_C) begin
            hpos_d = '0;
        end

        vpos_d = vpos_q;
        if (v_edge) begin
            vpos_d = V_EDGE_C;
        end else if (h_wrap) begin
            vpos_d = (vpos_q == V_MAX_C) ? '0 : vpos_q + 10'd1;
        end
    end

    // An edge coinciding with a timeout is the first edge after the gap and
    // therefore starts a fresh measurement instead of producing one.
    always_comb begin
        timeout    = (hcnt_q == CNT_SAT);
        meas_len   = timeout ? CNT_SAT : hcnt_q + 10'd1;
        line_load  = h_edge && seen_q && !timeout;
        bad_line   = line_load && (meas_len != LINE_CLKS);
        frame_good = (lcnt_q == FRAME_LINES);

        hcnt_d = h_edge ? '0 : (timeout ? hcnt_q : hcnt_q + 10'd1);

        seen_d = seen_q;
        if (h_edge) begin
            seen_d = 1'b1;
        end else if (timeout) begin
            seen_d = 1'b0;
        end

        line_len_d = line_load ? meas_len : line_len_q;

        lcnt_d = lcnt_q;
        if (v_edge) begin
            lcnt_d = '0;
        end else if (h_edge && (lcnt_q != CNT_SAT)) begin
            lcnt_d = lcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bad_d      = bad_q;
        sync_err_d = 1'b0;

        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = CHECK;
                    bad_d   = 1'b0;
                end
            end
            CHECK: begin
                if (bad_line) begin
                    bad_d = 1'b1;
                end
                if (timeout) begin
                    state_d = SEARCH;
                end else if (v_edge) begin
                    if (frame_good && !bad_q && !bad_line) begin
                        state_d = LOCKED;
                    end
                    bad_d = 1'b0;
                end
            end
            LOCKED: begin
                if (bad_line || timeout || (v_edge && !frame_good)) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q       <= '0;
            vs_q       <= '0;
            hpos_q     <= '0;
            vpos_q     <= '0;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            line_len_q <= '0;
            seen_q     <= 1'b0;
            bad_q      <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            state_q    <= SEARCH;
        end else begin
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            line_len_q <= line_len_d;
            seen_q     <= seen_d;
            bad_q      <= bad_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            state_q    <= state_d;
        end
    end

    assign sync_if.hpos       = hpos_q;
    assign sync_if.vpos       = vpos_q;
    assign sync_if.line_len   = line_len_q;
    assign sync_if.locked     = locked_q;
    assign sync_if.sync_err   = sync_err_q;
    assign sync_if.display_on = locked_q && (hpos_q < H_DISP_C) && (vpos_q < V_DISP_C);

endmodule
